// File: rtl/pb_bounce_if.sv
// Command/status bundle between a push-button emulator and whoever drives it.
// The master issues press and seed commands; the slave (the emulator) returns
// the button level and sequence status.
interface pb_bounce_if;
    logic        start;
    logic        seed_load;
    logic [15:0] seed;
    logic        pb_out;
    logic        busy;
    logic        done;
    logic [15:0] press_count;

    modport master (
        output start,
        output seed_load,
        output seed,
        input  pb_out,
        input  busy,
        input  done,
        input  press_count
    );

    modport slave (
        input  start,
        input  seed_load,
        input  seed,
        output pb_out,
        output busy,
        output done,
        output press_count
    );
endinterface

// File: rtl/pb_bounce_gen.sv
// Push-button emulator: on start, drives an LFSR-bounced press edge, a clean
// held press and then a release back to 0. Counts completed presses.
// Optional feature macro: PB_BOUNCE_RELEASE_EN adds a bounced release window
// after the held press; without it the release edge is clean.
module pb_bounce_gen #(
    parameter int unsigned BOUNCE_CYCLES = 200,
    parameter int unsigned PRESS_CYCLES  = 1000,
    parameter int unsigned TOG_W         = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    pb_bounce_if.slave  bus
);

    localparam int unsigned WIN_W  = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
    localparam logic [WIN_W-1:0]  WIN_MAX  = WIN_W'(BOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(PRESS_CYCLES - 1);
    localparam logic [15:0] SEED_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BOUNCE_DN = 2'd1,
        S_HOLD      = 2'd2
`ifdef PB_BOUNCE_RELEASE_EN
        , S_BOUNCE_UP = 2'd3
`endif
    } state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [WIN_W-1:0]  win_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TOG_W-1:0]  tog_cnt;
    logic              pb_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       count_q;

    logic [15:0]       lfsr_shift;
    logic              in_bounce;

    // Fibonacci LFSR, taps 16,14,13,11; a nonzero state never maps to zero
    assign lfsr_shift = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

`ifdef PB_BOUNCE_RELEASE_EN
    assign in_bounce = (state == S_BOUNCE_DN) || (state == S_BOUNCE_UP);
`else
    assign in_bounce = (state == S_BOUNCE_DN);
`endif

    // Sequencer: bounce toggling, window/hold timing, counters and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            lfsr     <= SEED_INIT;
            win_cnt  <= '0;
            hold_cnt <= '0;
            tog_cnt  <= '0;
            pb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= 16'h0000;
        end else begin
            done_q <= 1'b0;

            // Bounce: LFSR advances every cycle, level flips when the interval expires
            if (in_bounce) begin
                lfsr <= lfsr_shift;
                if (tog_cnt == '0) begin
                    pb_q    <= ~pb_q;
                    tog_cnt <= lfsr_shift[TOG_W-1:0];
                end else begin
                    tog_cnt <= tog_cnt - TOG_W'(1);
                end
                if (win_cnt != '0) begin
                    win_cnt <= win_cnt - WIN_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_BOUNCE_DN;
                        pb_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        win_cnt <= WIN_MAX;
                        tog_cnt <= lfsr[TOG_W-1:0];
                    end else if (bus.seed_load) begin
                        lfsr <= (bus.seed == 16'h0000) ? 16'h0001 : bus.seed;
                    end
                end
                S_BOUNCE_DN: begin
                    // Exit level is forced high whatever the bounce did last
                    if (win_cnt == '0) begin
                        state    <= S_HOLD;
                        pb_q     <= 1'b1;
                        hold_cnt <= HOLD_MAX;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
`ifdef PB_BOUNCE_RELEASE_EN
                        state   <= S_BOUNCE_UP;
                        pb_q    <= 1'b0;
                        win_cnt <= WIN_MAX;
                        tog_cnt <= lfsr[TOG_W-1:0];
`else
                        state   <= S_IDLE;
                        pb_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= count_q + 16'd1;
`endif
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
`ifdef PB_BOUNCE_RELEASE_EN
                S_BOUNCE_UP: begin
                    // Exit level is forced low whatever the bounce did last
                    if (win_cnt == '0) begin
                        state   <= S_IDLE;
                        pb_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= count_q + 16'd1;
                    end
                end
`endif
                default: begin
                    state  <= S_IDLE;
                    pb_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pb_out      = pb_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.press_count = count_q;

endmodule

// File: tb/tb_pb_bounce_gen.sv
// Bench for pb_bounce_gen: directed press sequences with randomized seeds,
// re-pulses and seed_load noise, checked against a toggle-schedule model.
module tb_pb_bounce_gen;

    localparam int unsigned B  = 16;
    localparam int unsigned P  = 32;
    localparam int unsigned TW = 2;
    localparam logic [15:0] SEED0 = 16'hACE1;
    localparam int unsigned TMASK = (1 << TW) - 1;
`ifdef PB_BOUNCE_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif
    localparam int unsigned BUSY_LEN = B + P + (REL ? B : 0);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pb_bounce_if bus();

    pb_bounce_gen #(
        .BOUNCE_CYCLES(B),
        .PRESS_CYCLES (P),
        .TOG_W        (TW),
        .LFSR_SEED    (SEED0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_lfsr;
    logic [15:0] m_count;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Expected level over one bounce window: toggle schedule from LFSR history
    task automatic gen_window(input logic [15:0] l0, input logic lvl0,
                              output logic [B-1:0] wave, output logic [15:0] lend);
        logic [15:0] lf [B+1];
        bit          flip [B+1];
        int          d;
        logic        lvl;
        lf[0] = l0;
        for (int k = 0; k < B; k++) lf[k+1] = lfsr_adv(lf[k]);
        for (int k = 0; k <= B; k++) flip[k] = 1'b0;
        d = int'(lf[0] & 16'(TMASK));
        while (d < int'(B)) begin
            flip[d+1] = 1'b1;
            d = d + 1 + int'(lf[d+1] & 16'(TMASK));
        end
        lvl = lvl0;
        for (int i = 0; i < int'(B); i++) begin
            if (flip[i]) lvl = ~lvl;
            wave[i] = lvl;
        end
        lend = lf[B];
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_pb"},    16'(bus.pb_out), 16'd0);
        check({tag, "_busy"},  16'(bus.busy),   16'd0);
        check({tag, "_done"},  16'(bus.done),   16'd0);
        check({tag, "_count"}, bus.press_count, m_count);
    endtask

    // Starts a press from IDLE and checks every cycle through the done pulse
    task automatic do_press(input string tag, input bit hold_busy, input bit keep_after,
                            input int rp_a, input int rp_b, output int n_tog);
        logic [B-1:0] w_dn;
        logic [B-1:0] w_up;
        logic [15:0]  ln;
        logic         exp_pb;
        logic         prev;
        bus.start     = 1'b1;
        bus.seed_load = 1'($urandom_range(0, 1));
        bus.seed      = 16'($urandom);
        gen_window(m_lfsr, 1'b1, w_dn, ln);
        m_lfsr = ln;
        w_up = '0;
        if (REL) begin
            gen_window(m_lfsr, 1'b0, w_up, ln);
            m_lfsr = ln;
        end
        step();
        prev  = 1'b1;
        n_tog = 0;
        for (int c = 1; c <= int'(BUSY_LEN); c++) begin
            if (c <= int'(B))          exp_pb = w_dn[c-1];
            else if (c <= int'(B + P)) exp_pb = 1'b1;
            else                       exp_pb = w_up[c-int'(B+P)-1];
            check({tag, "_pb"},   16'(bus.pb_out), 16'(exp_pb));
            check({tag, "_busy"}, 16'(bus.busy),   16'd1);
            check({tag, "_done"}, 16'(bus.done),   16'd0);
            if (c <= int'(B) && bus.pb_out !== prev) n_tog++;
            prev = bus.pb_out;
            bus.start     = hold_busy || (c == rp_a) || (c == rp_b);
            bus.seed_load = 1'($urandom_range(0, 1));
            bus.seed      = 16'($urandom);
            step();
        end
        m_count = m_count + 16'd1;
        check({tag, "_end_pb"},    16'(bus.pb_out), 16'd0);
        check({tag, "_end_busy"},  16'(bus.busy),   16'd0);
        check({tag, "_end_done"},  16'(bus.done),   16'd1);
        check({tag, "_end_count"}, bus.press_count, m_count);
        bus.start     = keep_after;
        bus.seed_load = 1'b0;
    endtask

    initial begin
        int          n;
        int          a;
        int          b2;
        logic [15:0] s;

        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed      = 16'h0000;
        m_lfsr        = SEED0;
        m_count       = 16'h0000;

        // Power-on reset, checked asynchronously before any clock edge
        #2 reset = 1'b1;
        #1;
        idle_check("reset");
        step();
        step();
        @(negedge clk) reset = 1'b0;
        step();
        idle_check("post_reset");

        // Single press from the reset seed
        do_press("t1", 1'b0, 1'b0, -1, -1, n);
        step();
        idle_check("t1_after");

        // Re-pulses during busy are ignored
        do_press("t2", 1'b0, 1'b0, 5, 30, n);
        step();
        idle_check("t2_after");

        // Start held high: back-to-back sequences with one IDLE cycle between
        do_press("t3a", 1'b1, 1'b1, -1, -1, n);
        do_press("t3b", 1'b1, 1'b1, -1, -1, n);
        do_press("t3c", 1'b1, 1'b1, -1, -1, n);
        do_press("t3d", 1'b1, 1'b0, -1, -1, n);
        step();
        idle_check("t3_after");

        // Zero seed substitutes 1 and still bounces
        bus.seed_load = 1'b1;
        bus.seed      = 16'h0000;
        step();
        bus.seed_load = 1'b0;
        m_lfsr = 16'h0001;
        idle_check("t4_idle");
        do_press("t4", 1'b0, 1'b0, -1, -1, n);
        check("t4_no_lockup", 16'(n >= 1), 16'd1);
        step();
        idle_check("t4_after");

        // Reset mid-bounce aborts the sequence without counting it
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("t5_busy_before", 16'(bus.busy), 16'd1);
        #2 reset = 1'b1;
        #1;
        m_count = 16'h0000;
        m_lfsr  = SEED0;
        check("t5_rst_pb",    16'(bus.pb_out), 16'd0);
        check("t5_rst_busy",  16'(bus.busy),   16'd0);
        check("t5_rst_count", bus.press_count, 16'd0);
        @(negedge clk) reset = 1'b0;
        step();
        idle_check("t5_idle");
        do_press("t5", 1'b0, 1'b0, -1, -1, n);
        step();
        idle_check("t5_after");

        // Random seeds, random idle gaps, random ignored re-pulses
        for (int r = 0; r < 6; r++) begin
            s = 16'($urandom);
            if (r == 0) s = 16'h0000;
            bus.seed_load = 1'b1;
            bus.seed      = s;
            step();
            bus.seed_load = 1'b0;
            m_lfsr = (s == 16'h0000) ? 16'h0001 : s;
            a = int'($urandom_range(0, 3));
            for (int g = 0; g < a; g++) begin
                idle_check("rnd_gap");
                step();
            end
            a  = int'($urandom_range(1, BUSY_LEN));
            b2 = int'($urandom_range(1, BUSY_LEN));
            do_press("rnd", 1'b0, 1'b0, a, b2, n);
            step();
            idle_check("rnd_after");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
